// File: rtl/alu_seq_if.sv
// Execute-stage ALU request/response bundle: valid/ready on both the operand and result sides.
interface alu_seq_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            op;
  logic [DATA_WIDTH-1:0] reg_1;
  logic [DATA_WIDTH-1:0] reg_2;
  logic [DATA_WIDTH-1:0] sign_extended_imm;
  logic                  alu_src;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero_flag;
  logic                  illegal_op;

  modport master (
    output in_valid, op, reg_1, reg_2, sign_extended_imm, alu_src, out_ready,
    input  in_ready, out_valid, result, zero_flag, illegal_op
  );

  modport slave (
    input  in_valid, op, reg_1, reg_2, sign_extended_imm, alu_src, out_ready,
    output in_ready, out_valid, result, zero_flag, illegal_op
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential execute-stage ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add multiplier and restoring divider sharing one 2*DATA_WIDTH accumulator.
module alu_seq #(
  parameter int DATA_WIDTH = 64,
  parameter bit MULDIV_EN  = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2, OP_OR   = 4'd3,
                         OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6, OP_SLL = 4'd7,
                         OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_MUL = 4'd10, OP_MULHU = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  logic [3:0]     op_q;
  logic [W-1:0]   acc_hi, acc_lo, opnd;
  logic [SW-1:0]  cnt;
  logic [W-1:0]   res_q;
  logic           zero_q, ill_q;

  logic [W-1:0]   b_sel;
  logic [SW-1:0]  shamt;
  logic           is_md, md_go, ill, acc_go;
  logic [W-1:0]   alu_res;

  assign b_sel  = bus.alu_src ? bus.sign_extended_imm : bus.reg_2;
  assign shamt  = b_sel[SW-1:0];
  assign is_md  = (bus.op >= 4'd10) && (bus.op <= 4'd13);
  assign md_go  = is_md && MULDIV_EN;
  assign ill    = (bus.op >= 4'd14) || (is_md && !MULDIV_EN);

  assign bus.in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign acc_go       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.reg_1 + b_sel;
      OP_SUB:  alu_res = bus.reg_1 - b_sel;
      OP_AND:  alu_res = bus.reg_1 & b_sel;
      OP_OR:   alu_res = bus.reg_1 | b_sel;
      OP_XOR:  alu_res = bus.reg_1 ^ b_sel;
      OP_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(bus.reg_1) < $signed(b_sel))};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, (bus.reg_1 < b_sel)};
      OP_SLL:  alu_res = bus.reg_1 << shamt;
      OP_SRL:  alu_res = bus.reg_1 >> shamt;
      OP_SRA:  alu_res = W'($signed(bus.reg_1) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration of each algorithm. Multiply: acc_lo holds the multiplier and shifts
  // product bits in from the top. Divide: acc_hi is the partial remainder, acc_lo the
  // dividend shifting out / quotient shifting in.
  logic [W:0]   mul_sum, div_shift, div_trial;
  logic [W-1:0] step_hi, step_lo, fin;
  logic         is_mul_q;

  assign is_mul_q  = (op_q == OP_MUL) || (op_q == OP_MULHU);
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[W-1]};
  assign div_trial = div_shift - {1'b0, opnd};

  always_comb begin
    if (is_mul_q) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], acc_lo[W-1:1]};
    end else begin
      step_hi = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
      step_lo = {acc_lo[W-2:0], ~div_trial[W]};
    end
  end

  // MUL/DIVU take the low half, MULHU/REMU the high half.
  assign fin = op_q[0] ? step_hi : step_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else if (acc_go) begin
      if (md_go) begin
        state  <= BUSY;
        op_q   <= bus.op;
        acc_hi <= '0;
        acc_lo <= bus.reg_1;
        opnd   <= b_sel;
        cnt    <= '0;
      end else begin
        state  <= DONE;
        res_q  <= ill ? '0 : alu_res;
        zero_q <= !ill && (alu_res == '0);
        ill_q  <= ill;
      end
    end else begin
      case (state)
        BUSY: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == SW'(W-1)) begin
            state  <= DONE;
            res_q  <= fin;
            zero_q <= (fin == '0);
            ill_q  <= 1'b0;
          end
        end
        DONE:    if (bus.out_ready) state <= IDLE;
        default: state <= state;
      endcase
    end
  end

  assign bus.out_valid  = (state == DONE);
  assign bus.result     = res_q;
  assign bus.zero_flag  = zero_q;
  assign bus.illegal_op = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at DATA_WIDTH=64 with the mul/div unit present.
module tb_alu_seq;
  localparam int W = 64;
  localparam logic [3:0] ADD = 0, SUB = 1, XOR_ = 4, SLT = 5, SLTU = 6, SLL = 7, SRL = 8,
                         SRA = 9, MUL = 10, MULHU = 11, DIVU = 12, REMU = 13;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  alu_seq_if #(.DATA_WIDTH(W)) bus ();
  alu_seq #(.DATA_WIDTH(W), .MULDIV_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic src);
    bus.op = op; bus.reg_1 = a; bus.reg_2 = b; bus.sign_extended_imm = imm; bus.alu_src = src;
  endtask

  // Called just after a rising edge with the DUT idle and out_ready=1.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] imm, input logic src,
                       input logic [W-1:0] exp_res, input logic exp_zero, input logic exp_ill,
                       input int exp_lat);
    int lat = 0;
    int rdy_hi = 0;
    drive(op, a, b, imm, src);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    drive(4'd0, 64'hDEAD, 64'hBEEF, 64'h0, 1'b0);
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_hi++;
    end
    chk({tag, ".lat"},    W'(lat), W'(exp_lat));
    chk({tag, ".busy_rdy"}, W'(rdy_hi), '0);
    chk({tag, ".res"},    bus.result, exp_res);
    chk({tag, ".zero"},   W'(bus.zero_flag), W'(exp_zero));
    chk({tag, ".ill"},    W'(bus.illegal_op), W'(exp_ill));
    @(posedge clk); #1;
  endtask

  initial begin
    int vcount;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd0, '0, '0, '0, 1'b0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", W'(bus.out_valid), '0);
    chk("rst.res",   bus.result, '0);
    chk("rst.zero",  W'(bus.zero_flag), '0);
    chk("rst.ill",   W'(bus.illegal_op), '0);
    chk("rst.rdy",   W'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst.valid", W'(bus.out_valid), '0);
    @(posedge clk); #1;

    do_op("add", ADD, 64'd5, 64'd7, 64'd0, 1'b0, 64'd12, 1'b0, 1'b0, 1);

    // back-to-back: one result per cycle
    drive(SUB, 64'd9, 64'd9, 64'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(SLT, ONES, 64'd1, 64'd0, 1'b0);
    @(negedge clk);
    chk("b2b.sub.valid", W'(bus.out_valid), 64'd1);
    chk("b2b.sub.res",   bus.result, '0);
    chk("b2b.sub.zero",  W'(bus.zero_flag), 64'd1);
    @(posedge clk); #1;
    drive(SRA, 64'h8000_0000_0000_0000, 64'h55, 64'd4, 1'b1);
    @(negedge clk);
    chk("b2b.slt.valid", W'(bus.out_valid), 64'd1);
    chk("b2b.slt.res",   bus.result, 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.sra.valid", W'(bus.out_valid), 64'd1);
    chk("b2b.sra.res",   bus.result, 64'hF800_0000_0000_0000);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b.idle", W'(bus.out_valid), '0);
    @(posedge clk); #1;

    do_op("xor",  XOR_, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 64'h0FF0, 1'b0, 1'b0, 1);
    do_op("sltu", SLTU, 64'd1, ONES, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0, 1);
    do_op("sll",  SLL, 64'd1, 64'h13F, 64'd0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1);
    do_op("srl",  SRL, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 1'b1, 64'd1, 1'b0, 1'b0, 1);

    do_op("mul",   MUL,   ONES, 64'd2, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, W+1);
    do_op("mulhu", MULHU, ONES, 64'd2, 64'd0, 1'b0, 64'd1, 1'b0, 1'b0, W+1);
    do_op("divu",  DIVU,  64'd100, 64'd7, 64'd0, 1'b0, 64'd14, 1'b0, 1'b0, W+1);
    do_op("remu",  REMU,  64'd100, 64'd0, 64'd7, 1'b1, 64'd2, 1'b0, 1'b0, W+1);
    do_op("divu0", DIVU,  64'd5, 64'd0, 64'd0, 1'b0, ONES, 1'b0, 1'b0, W+1);
    do_op("remu0", REMU,  64'd5, 64'd0, 64'd0, 1'b0, 64'd5, 1'b0, 1'b0, W+1);

    // backpressure: result held, new request ignored
    bus.out_ready = 1'b0;
    drive(ADD, 64'd1, 64'd1, 64'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    drive(ADD, 64'd3, 64'd3, 64'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp.valid", W'(bus.out_valid), 64'd1);
      chk("bp.res",   bus.result, 64'd2);
      chk("bp.rdy",   W'(bus.in_ready), '0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.release.res", bus.result, 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp.drained", W'(bus.out_valid), '0);
    @(posedge clk); #1;

    do_op("ill15", 4'd15, 64'd3, 64'd4, 64'd0, 1'b0, '0, 1'b0, 1'b1, 1);
    do_op("ill14", 4'd14, 64'd0, 64'd0, 64'd0, 1'b0, '0, 1'b0, 1'b1, 1);

    // reset during BUSY discards the division
    drive(DIVU, 64'd100, 64'd7, 64'd0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort.valid", W'(bus.out_valid), '0);
    chk("abort.rdy",   W'(bus.in_ready), 64'd1);
    chk("abort.res",   bus.result, '0);
    vcount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("abort.no_result", W'(vcount), '0);
    @(posedge clk); #1;
    do_op("recover", ADD, ONES, 64'd1, 64'd0, 1'b0, '0, 1'b1, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
